// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Receiver state encoding, frame geometry, common scan codes and parity helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_DATA   = 4'b0010,
        ST_PARITY = 4'b0100,
        ST_STOP   = 4'b1000
    } rx_state_e;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_LCTRL  = 8'h14;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Byte FIFO between the PS/2 receiver and the display-side pop logic.
// Extra pointer MSB distinguishes full from empty; storage itself is not reset.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-frame receiver: synchronise, deframe, check, buffer, and pace bytes
// out as a data/one-cycle-flag pair with a minimum spacing of GAP cycles.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a start bit (data low on a fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | next fall carries the parity bit
// ST_STOP   | next fall carries the stop bit; push or reject
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2dis_data,
    output logic       ps2dis_recFlag,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] err_cnt
);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int GW        = (GAP > 1) ? $clog2(GAP) : 1;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    rx_state_e   state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        push_q, push_d;
    logic [7:0]  push_byte_q, push_byte_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        tmo_d       = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TW'(1);

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT)) begin
            // Device stalled mid-frame: abandon the partial byte.
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end

        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [GW-1:0] gap_q, gap_d;
    logic          flag_q, flag_d;
    logic [7:0]    data_q, data_d;
    logic          overflow_q, overflow_d;

    // Full and empty are both judged before this cycle's pop/push take effect.
    assign fifo_push = push_q & ~fifo_full;
    assign fifo_pop  = ~fifo_empty & (gap_q == '0) & ~flag_q;

    ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_byte_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        flag_d     = fifo_pop;
        data_d     = data_q;
        overflow_d = overflow_q | (push_q & fifo_full);
        if (fifo_pop) begin
            gap_d  = GW'(GAP - 1);
            data_d = fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q      <= '0;
            flag_q     <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            gap_q      <= gap_d;
            flag_q     <= flag_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign ps2dis_data    = data_q;
    assign ps2dis_recFlag = flag_q;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;
    assign err_cnt        = err_cnt_q;

endmodule
